// File: rtl/mips_loader_pkg.sv
// Shared constants for the instruction loader and the instruction memory.
// Holds the FSM state encoding, the HALT opcode and the opcode field position.
// The CKSUM state exists only when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
package mips_loader_pkg;

    // Opcode occupies the top OPCODE_W bits of every instruction word.
    localparam int          OPCODE_W    = 6;
    localparam int          OPCODE_MSB  = 31;
    localparam int          OPCODE_LSB  = OPCODE_MSB - OPCODE_W + 1;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_SETUP = 3'd2,
        ST_WRITE = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        ,
        ST_CKSUM = 3'd6
`endif
    } state_e;

    // True when the opcode field of an instruction is the HALT opcode.
    function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode);
        return opcode == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs incoming bytes MSB first into a word.
// word_next_o is the word as it will look after the current shift, so the
// caller can capture a completed word in the same cycle the last byte lands.
module word_assembler #(
    parameter int LEN_DATA = 32,
    parameter int LEN_BYTE = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                shift_i,
    input  logic [LEN_BYTE-1:0] byte_i,
    output logic [LEN_DATA-1:0] word_next_o,
    output logic                word_valid_o
);

    localparam int BYTES = LEN_DATA / LEN_BYTE;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [LEN_DATA-1:0] word_q;
    logic [CNT_W-1:0]    cnt_q;

    assign word_next_o  = {word_q[LEN_DATA-LEN_BYTE-1:0], byte_i};
    assign word_valid_o = shift_i && (cnt_q == CNT_W'(BYTES - 1));

    // Shift register and byte counter; the counter rolls over on a full word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift_i) begin
            word_q <= word_next_o;
            cnt_q  <= word_valid_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Write-side master for the instruction memory: turns the UART byte stream
// into 32-bit instructions and writes them from address 0 upward until HALT
// or memory full. Optional macro INSTRUCTION_LOADER_CHECKSUM_EN adds a
// trailing XOR checksum byte after the HALT word.
module instruction_loader
    import mips_loader_pkg::*;
#(
    parameter int len_addr  = 7,
    parameter int len_data  = 32,
    parameter int ram_depth = 128,
    parameter int len_byte  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                rx_done,
    input  logic [len_byte-1:0] rx_data,
    output logic                Wr,
    output logic [len_addr-1:0] Addr,
    output logic [len_data-1:0] In_Data,
    output logic                busy,
    output logic                load_done,
    output logic                error
);

    localparam logic [len_addr-1:0] LAST_ADDR = len_addr'(ram_depth - 1);

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic [len_addr-1:0] addr_q, addr_d;
    logic [len_data-1:0] data_q, data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [len_byte-1:0] xor_q, xor_d;
`endif

    logic                asm_clear, asm_shift, asm_valid;
    logic [len_data-1:0] asm_word_next;

    word_assembler #(
        .LEN_DATA (len_data),
        .LEN_BYTE (len_byte)
    ) u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (asm_clear),
        .shift_i      (asm_shift),
        .byte_i       (rx_data),
        .word_next_o  (asm_word_next),
        .word_valid_o (asm_valid)
    );

    assign Wr        = wr_q;
    assign Addr      = addr_q;
    assign In_Data   = data_q;
    assign load_done = done_q;
    assign error     = err_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);

    // State and output registers; everything clears asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    // Next-state and output logic. In_Data is captured on the edge that
    // completes the word, so it is already stable the cycle before Wr rises.
    always_comb begin
        state_d   = state_q;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = done_q;
        err_d     = err_q;
        asm_clear = 1'b0;
        asm_shift = 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RECV;
                    addr_d    = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    asm_clear = 1'b1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    xor_d     = '0;
`endif
                end
            end
            ST_RECV: begin
                if (rx_done) begin
                    asm_shift = 1'b1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    xor_d     = xor_q ^ rx_data;
`endif
                    if (asm_valid) begin
                        data_d  = asm_word_next;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                wr_d    = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (is_halt(data_q[len_data-1 -: OPCODE_W])) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    state_d = ST_CKSUM;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
`endif
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    addr_d    = addr_q + 1'b1;
                    asm_clear = 1'b1;
                    state_d   = ST_RECV;
                end
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            ST_CKSUM: begin
                if (rx_done) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = (rx_data != xor_q);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized self-checking bench for instruction_loader against a byte-level
// session model (queue of expected memory writes plus final status).
module tb_instruction_loader;

    localparam int RD = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        Wr;
    logic [6:0]  Addr;
    logic [31:0] In_Data;
    logic        busy, load_done, error;

    instruction_loader dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .Wr        (Wr),
        .Addr      (Addr),
        .In_Data   (In_Data),
        .busy      (busy),
        .load_done (load_done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed { logic [6:0] a; logic [31:0] d; } wr_t;
    wr_t exp_q[$];

    // Model: phase 0 idle, 1 loading, 2 awaiting checksum, 3 done
    int         m_phase = 0;
    logic [6:0] m_addr = 0;
    logic [31:0] m_word = 0;
    int         m_nb = 0;
    logic [7:0] m_xor = 0;
    logic       m_done = 0, m_err = 0;
    int         last_rx_cyc = -100;
    int         n_wr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle checker of the write port.
    task automatic monitor();
        logic        wr_prev = 1'b0;
        logic [6:0]  a_prev = '0;
        logic [31:0] d_prev = '0;
        wr_t         e;
        forever begin
            @(negedge clk);
            if (Wr && !wr_prev) begin
                n_wr++;
                chk("wr_latency", cyc - last_rx_cyc, 2);
                chk("addr_stable_before", {25'd0, Addr}, {25'd0, a_prev});
                chk("data_stable_before", In_Data, d_prev);
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {25'd0, Addr}, {25'd0, e.a});
                    chk("wr_data", In_Data, e.d);
                end
            end
            if (wr_prev) begin
                chk("wr_width", {31'd0, Wr}, 32'd0);
                chk("addr_stable_after", {25'd0, Addr}, {25'd0, a_prev});
                chk("data_stable_after", In_Data, d_prev);
            end
            wr_prev = Wr;
            a_prev  = Addr;
            d_prev  = In_Data;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_phase == 1) begin
            m_word = {m_word[23:0], b};
            m_xor  = m_xor ^ b;
            m_nb++;
            if (m_nb == 4) begin
                m_nb = 0;
                exp_q.push_back({m_addr, m_word});
                if (m_word[31:26] == 6'h3F) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    m_phase = 2;
`else
                    m_phase = 3; m_done = 1; m_err = 0;
`endif
                end else if (m_addr == 7'(RD - 1)) begin
                    m_phase = 3; m_done = 1; m_err = 1;
                end else begin
                    m_addr = m_addr + 1;
                end
            end
        end else if (m_phase == 2) begin
            m_phase = 3; m_done = 1; m_err = (b != m_xor);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_done = 1'b1; rx_data = b; last_rx_cyc = cyc;
        model_byte(b);
        @(posedge clk); #1;
        rx_done = 1'b0; rx_data = $urandom_range(0, 255);
        repeat (4) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        if (m_phase == 0 || m_phase == 3) begin
            m_phase = 1; m_addr = 0; m_nb = 0; m_xor = 0; m_done = 0; m_err = 0;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_halt();
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        send_byte(m_xor);
`endif
    endtask

    function automatic logic [31:0] rand_nonhalt();
        logic [31:0] w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    task automatic check_end(input string nm);
        int k = 0;
        while (busy && k < 60) begin
            @(negedge clk); k++;
        end
        @(negedge clk);
        $display("-- %s", nm);
        chk("settle_timeout", {31'd0, busy}, 32'd0);
        chk("load_done", {31'd0, load_done}, {31'd0, m_done});
        chk("error", {31'd0, error}, {31'd0, m_err});
        chk("final_addr", {25'd0, Addr}, {25'd0, m_addr});
        chk("pending_writes", exp_q.size(), 32'd0);
    endtask

    initial begin
        int base;
        fork monitor(); join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr", {31'd0, Wr}, 32'd0);
        chk("rst_addr", {25'd0, Addr}, 32'd0);
        chk("rst_data", In_Data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_err", {31'd0, error}, 32'd0);
        rst_n = 1'b1;

        // Bytes in IDLE are ignored
        send_word(32'hFC000000);
        check_end("rx_in_idle");
        chk("idle_data", In_Data, 32'd0);

        // Directed two-word program with pinned literals
        base = n_wr;
        pulse_start();
        send_word(32'h20010005);
        send_word(32'hFC000000);
        finish_halt();
        check_end("two_word");
        chk("lit_done", {31'd0, load_done}, 32'd1);
        chk("lit_err", {31'd0, error}, 32'd0);
        chk("lit_addr", {25'd0, Addr}, 32'd1);
        chk("lit_data", In_Data, 32'hFC000000);
        chk("lit_nwr", n_wr - base, 32'd2);

        // Random programs terminated by HALT
        for (int p = 0; p < 4; p++) begin
            pulse_start();
            repeat ($urandom_range(1, 8)) send_word(rand_nonhalt());
            send_word({6'h3F, 26'($urandom)});
            finish_halt();
            check_end("rand_prog");
        end

        // start during RECV is ignored
        pulse_start();
        send_byte(8'h12); send_byte(8'h34);
        pulse_start();
        send_byte(8'h56); send_byte(8'h78);
        send_word(32'hFFFFFFFF);
        finish_halt();
        check_end("start_in_recv");

        // Full memory without HALT
        base = n_wr;
        pulse_start();
        for (int i = 0; i < RD; i++) send_word(rand_nonhalt());
        check_end("mem_full");
        chk("full_nwr", n_wr - base, 32'd128);
        chk("full_err", {31'd0, error}, 32'd1);
        chk("full_addr", {25'd0, Addr}, 32'd127);

        // Bytes in DONE are ignored, no wrap
        send_word(32'hFC000000);
        check_end("rx_in_done");

        // Reset mid-word
        pulse_start();
        send_byte(8'hAB); send_byte(8'hCD);
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_phase = 0; m_addr = 0; m_nb = 0; m_xor = 0; m_done = 0; m_err = 0;
        #1;
        chk("arst_addr", {25'd0, Addr}, 32'd0);
        chk("arst_data", In_Data, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, load_done}, 32'd0);
        chk("arst_wr", {31'd0, Wr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        send_word(32'hFC000007);
        finish_halt();
        check_end("after_reset");
        chk("arst_reload_data", In_Data, 32'hFC000007);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        pulse_start();
        send_word(32'hFC000000);
        send_byte(8'hFC);
        check_end("cksum_good");
        chk("cksum_good_err", {31'd0, error}, 32'd0);
        pulse_start();
        send_word(32'hFC000000);
        send_byte(8'h00);
        check_end("cksum_bad");
        chk("cksum_bad_err", {31'd0, error}, 32'd1);
`endif

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
